// File: rtl/stepper_pkg.sv
// Shared types and helpers for the microstepping stepper controller.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Phase encoding: index of the first energised coil of the pair.
    typedef enum logic [1:0] {
        PH_AB = 2'd0,
        PH_BC = 2'd1,
        PH_CD = 2'd2,
        PH_DA = 2'd3
    } phase_t;

    localparam int NUM_COILS = 4;

    // Coil index (p + k) mod 4; the 2-bit sum wraps naturally.
    function automatic logic [1:0] coil_idx(input logic [1:0] p, input logic [1:0] k);
        return p + k;
    endfunction

endpackage

// File: rtl/stepper_tick_gen.sv
// Microstep tick generator: one-cycle tick every max(div, 1) enabled cycles.
module stepper_tick_gen #(
    parameter int DIV_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] period_reg;

    // Reload value for a period of max(d, 1) cycles.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction

    // Down-counter: load latches the period, clr zeroes it, en counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            period_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            period_reg <= div;
            cnt_reg    <= reload_of(div);
        end else if (en) begin
            if (cnt_reg == '0) begin
                cnt_reg <= reload_of(period_reg);
            end else begin
                cnt_reg <= cnt_reg - DIV_W'(1);
            end
        end
    end

    assign tick = en && !load && !clr && (cnt_reg == '0);

endmodule

// File: rtl/stepper_microstep_ctrl.sv
// Two-phase stepper controller: commanded moves with microstep crossfade,
// optional holding torque, and a persistent full-step position/phase.
module stepper_microstep_ctrl
    import stepper_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int DUTY_MAX   = 255,
    parameter int DUTY_MIN   = 7,
    parameter int USTEP_LOG2 = 3,
    parameter int STEPS_W    = 10,
    parameter int DIV_W      = 9,
    parameter int POS_W      = 16,
    parameter int HOLD_DUTY  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_dir,
    input  logic [STEPS_W-1:0] i_steps,
    input  logic [DIV_W-1:0]   i_div,
    input  logic               i_hold,
    output logic [DUTY_W-1:0]  o_coil_a,
    output logic [DUTY_W-1:0]  o_coil_b,
    output logic [DUTY_W-1:0]  o_coil_c,
    output logic [DUTY_W-1:0]  o_coil_d,
    output logic               o_busy,
    output logic               o_done,
    output logic [POS_W-1:0]   o_pos,
    output logic [1:0]         o_phase
);

    localparam int STEP = (DUTY_MAX - DUTY_MIN) >> USTEP_LOG2;

    state_t                  state_reg, state_next;
    logic [USTEP_LOG2-1:0]   m_reg, m_next;
    logic [1:0]              phase_reg, phase_next;
    logic [POS_W-1:0]        pos_reg, pos_next;
    logic [STEPS_W-1:0]      remaining_reg, remaining_next;
    logic                    dir_reg, dir_next;
    logic                    hold_reg, hold_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic [DUTY_W-1:0]       trail_duty, lead_duty;
    logic                    accept;
    logic                    tick;

    // A start is honoured outside RUN unless an abort arrives with it.
    assign accept = i_start && !i_abort && (state_reg != ST_RUN);

    stepper_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .clr  (i_abort),
        .en   (state_reg == ST_RUN),
        .div  (i_div),
        .tick (tick)
    );

    // State register with move context, microstep and position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            m_reg         <= '0;
            phase_reg     <= PH_AB;
            pos_reg       <= '0;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
            hold_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            m_reg         <= m_next;
            phase_reg     <= phase_next;
            pos_reg       <= pos_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            hold_reg      <= hold_next;
        end
    end

    // Next-state logic: abort beats start; microstep ticks advance the move.
    always_comb begin
        state_next     = state_reg;
        m_next         = m_reg;
        phase_next     = phase_reg;
        pos_next       = pos_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        hold_next      = hold_reg;
        done_next      = 1'b0;
        if (i_abort) begin
            state_next = ST_IDLE;
            m_next     = '0;
        end else if (accept) begin
            dir_next       = i_dir;
            hold_next      = i_hold;
            m_next         = '0;
            remaining_next = i_steps;
            if (i_steps == '0) begin
                state_next = i_hold ? ST_HOLD : ST_IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = ST_RUN;
            end
        end else if ((state_reg == ST_RUN) && tick) begin
            if (&m_reg) begin
                // Last microstep of a full step: move to the next coil pair.
                m_next         = '0;
                phase_next     = dir_reg ? phase_reg + 2'd1 : phase_reg - 2'd1;
                pos_next       = dir_reg ? pos_reg + POS_W'(1) : pos_reg - POS_W'(1);
                remaining_next = remaining_reg - STEPS_W'(1);
                if (remaining_reg == STEPS_W'(1)) begin
                    state_next = hold_reg ? ST_HOLD : ST_IDLE;
                    done_next  = 1'b1;
                end
            end else begin
                m_next = m_reg + USTEP_LOG2'(1);
            end
        end
    end

    // Output logic: crossfade duties and busy flag derived from next state.
    always_comb begin
        trail_duty = DUTY_W'(DUTY_MAX - int'(m_next) * STEP);
        lead_duty  = DUTY_W'(DUTY_MIN + int'(m_next) * STEP);
        busy_next  = (state_next == ST_RUN);
    end

    for (genvar gi = 0; gi < NUM_COILS; gi++) begin : g_coil
        logic [DUTY_W-1:0] duty_next;
        logic [DUTY_W-1:0] duty_reg;
        logic              is_first;
        logic              is_second;

        // Coil gi is the first (p) or second (p+1) coil of the energised pair.
        always_comb begin
            is_first  = (2'(gi) == coil_idx(phase_next, 2'd0));
            is_second = (2'(gi) == coil_idx(phase_next, 2'd1));
            duty_next = '0;
            if (state_next == ST_RUN) begin
                if (is_first) begin
                    duty_next = dir_next ? trail_duty : lead_duty;
                end else if (is_second) begin
                    duty_next = dir_next ? lead_duty : trail_duty;
                end
            end else if (state_next == ST_HOLD) begin
                if (is_first || is_second) begin
                    duty_next = DUTY_W'(HOLD_DUTY);
                end
            end
        end

        // Registered coil duty.
        always_ff @(posedge clk) begin
            if (rst) begin
                duty_reg <= '0;
            end else begin
                duty_reg <= duty_next;
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign o_coil_a = g_coil[0].duty_reg;
    assign o_coil_b = g_coil[1].duty_reg;
    assign o_coil_c = g_coil[2].duty_reg;
    assign o_coil_d = g_coil[3].duty_reg;
    assign o_busy   = busy_reg;
    assign o_done   = done_reg;
    assign o_pos    = pos_reg;
    assign o_phase  = phase_reg;

endmodule

// File: tb/tb_stepper_microstep_ctrl.sv
// Bench for stepper_microstep_ctrl: per-cycle model comparison plus
// directed moves with hand-computed expectations.
module tb_stepper_microstep_ctrl;

    localparam int U         = 8;
    localparam int DUTY_MAX  = 255;
    localparam int DUTY_MIN  = 7;
    localparam int HOLD_DUTY = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_dir, i_hold;
    logic [9:0]  i_steps;
    logic [8:0]  i_div;
    logic [7:0]  o_coil_a, o_coil_b, o_coil_c, o_coil_d;
    logic        o_busy, o_done;
    logic [15:0] o_pos;
    logic [1:0]  o_phase;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    stepper_microstep_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_dir    (i_dir),
        .i_steps  (i_steps),
        .i_div    (i_div),
        .i_hold   (i_hold),
        .o_coil_a (o_coil_a),
        .o_coil_b (o_coil_b),
        .o_coil_c (o_coil_c),
        .o_coil_d (o_coil_d),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_pos    (o_pos),
        .o_phase  (o_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cycle, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ms: 0 idle, 1 moving, 2 holding. During a move the position is derived
    // from elapsed cycles; m_phase/m_pos hold the value at move start.
    int ms = 0, m_phase = 0, m_pos = 0, m_dir = 0, m_hold = 0;
    int m_div = 1, m_steps = 0, m_elapsed = 0, m_done = 0;
    bit m_valid = 1'b0;

    function automatic int wrap4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    function automatic int steps_done();
        return m_elapsed / (m_div * U);
    endfunction

    function automatic int cur_phase();
        if (ms != 1) return m_phase;
        return wrap4(m_phase + (m_dir != 0 ? steps_done() : -steps_done()));
    endfunction

    function automatic int cur_pos();
        if (ms != 1) return m_pos & 32'hFFFF;
        return (m_pos + (m_dir != 0 ? steps_done() : -steps_done())) & 32'hFFFF;
    endfunction

    function automatic int exp_coil(input int c);
        int p, mu, trail, lead;
        if (ms == 0) return 0;
        p = cur_phase();
        if (ms == 2) return (c == p || c == wrap4(p + 1)) ? HOLD_DUTY : 0;
        mu    = (m_elapsed / m_div) % U;
        trail = DUTY_MAX - mu * ((DUTY_MAX - DUTY_MIN) / U);
        lead  = DUTY_MIN + mu * ((DUTY_MAX - DUTY_MIN) / U);
        if (c == p)            return (m_dir != 0) ? trail : lead;
        if (c == wrap4(p + 1)) return (m_dir != 0) ? lead : trail;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ms <= 0; m_phase <= 0; m_pos <= 0; m_done <= 0; m_valid <= 1'b1;
        end else begin
            m_done <= 0;
            if (i_abort) begin
                if (ms == 1) begin
                    m_phase <= cur_phase();
                    m_pos   <= cur_pos();
                end
                ms <= 0;
            end else if (i_start && ms != 1) begin
                m_dir     <= int'(i_dir);
                m_hold    <= int'(i_hold);
                m_div     <= (i_div == 0) ? 1 : int'(i_div);
                m_steps   <= int'(i_steps);
                m_elapsed <= 0;
                if (i_steps == 0) begin
                    m_done <= 1;
                    ms     <= i_hold ? 2 : 0;
                end else begin
                    ms <= 1;
                end
            end else if (ms == 1) begin
                if (m_elapsed + 1 == m_steps * U * m_div) begin
                    ms      <= (m_hold != 0) ? 2 : 0;
                    m_done  <= 1;
                    m_phase <= wrap4(m_phase + (m_dir != 0 ? m_steps : -m_steps));
                    m_pos   <= (m_pos + (m_dir != 0 ? m_steps : -m_steps)) & 32'hFFFF;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_busy",  int'(o_busy),   (ms == 1) ? 1 : 0);
            check("model_done",  int'(o_done),   m_done);
            check("model_pos",   int'(o_pos),    cur_pos());
            check("model_phase", int'(o_phase),  cur_phase());
            check("model_coil_a", int'(o_coil_a), exp_coil(0));
            check("model_coil_b", int'(o_coil_b), exp_coil(1));
            check("model_coil_c", int'(o_coil_c), exp_coil(2));
            check("model_coil_d", int'(o_coil_d), exp_coil(3));
        end
    end

    // ---------------- directed stimulus ----------------
    int q_a[$], q_b[$], q_c[$], q_d[$];

    task automatic launch(input int steps, input bit dir, input int div, input bit hold);
        i_steps = 10'(steps);
        i_dir   = dir;
        i_div   = 9'(div);
        i_hold  = hold;
        i_start = 1'b1;
    endtask

    // Follow a move until o_done, tracing coils, then watch 3 extra cycles.
    task automatic run_move(input int limit, output int busy_cnt, output int done_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            q_a.push_back(int'(o_coil_a));
            q_b.push_back(int'(o_coil_b));
            q_c.push_back(int'(o_coil_c));
            q_d.push_back(int'(o_coil_d));
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                seen = 1'b1;
            end
        end
        check("move_done_seen", int'(seen), 1);
        repeat (3) begin
            @(negedge clk);
            if (o_done) done_cnt++;
            if (o_busy) busy_cnt++;
        end
    endtask

    function automatic int coil_sum();
        return int'(o_coil_a) + int'(o_coil_b) + int'(o_coil_c) + int'(o_coil_d);
    endfunction

    initial begin
        int bc, dc, bc2;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_dir = 1'b0;
        i_steps = '0; i_div = '0; i_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(o_busy), 0);
        check("reset_done", int'(o_done), 0);
        check("reset_pos", int'(o_pos), 0);
        check("reset_phase", int'(o_phase), 0);
        check("reset_coils", coil_sum(), 0);
        rst = 1'b0;

        // Forward: 2 steps, div 4, from AB.
        launch(2, 1'b1, 4, 1'b0);
        run_move(2000, bc, dc);
        $display("fwd: busy=%0d done=%0d pos=%0d phase=%0d", bc, dc, o_pos, o_phase);
        check("fwd_busy_cycles", bc, 64);
        check("fwd_done_count", dc, 1);
        check("fwd_a_m0", q_a[0], 255);
        check("fwd_b_m0", q_b[0], 7);
        check("fwd_a_m0_held", q_a[3], 255);
        check("fwd_a_m1", q_a[4], 224);
        check("fwd_b_m1", q_b[4], 38);
        check("fwd_a_m7", q_a[31], 38);
        check("fwd_b_m7", q_b[31], 224);
        check("fwd_bc_b_trail", q_b[32], 255);
        check("fwd_bc_c_lead", q_c[32], 7);
        check("fwd_pos", int'(o_pos), 2);
        check("fwd_phase", int'(o_phase), 2);
        check("fwd_coils_off", coil_sum(), 0);

        // Reverse from CD: coil D trails, coil C leads.
        launch(1, 1'b0, 1, 1'b0);
        run_move(2000, bc, dc);
        $display("rev: busy=%0d done=%0d pos=%0d phase=%0d", bc, dc, o_pos, o_phase);
        check("rev_busy_cycles", bc, 8);
        check("rev_done_count", dc, 1);
        check("rev_d_trail", q_d[0], 255);
        check("rev_c_lead", q_c[0], 7);
        check("rev_pos", int'(o_pos), 1);
        check("rev_phase", int'(o_phase), 1);

        // Abort after 10 cycles of a 3-step, div-2 move.
        launch(3, 1'b1, 2, 1'b0);
        bc = 0;
        repeat (10) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_busy) bc++;
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_busy_before", bc, 10);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_coils", coil_sum(), 0);
        check("abort_pos", int'(o_pos), 1);
        check("abort_phase", int'(o_phase), 1);
        dc = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_done) dc++;
        end
        check("abort_no_done", dc, 0);
        $display("abort: pos=%0d phase=%0d", o_pos, o_phase);

        // Resume from retained phase BC.
        launch(1, 1'b1, 1, 1'b0);
        run_move(2000, bc, dc);
        check("resume_b_trail", q_b[0], 255);
        check("resume_c_lead", q_c[0], 7);
        check("resume_pos", int'(o_pos), 2);
        check("resume_phase", int'(o_phase), 2);

        // Zero-step move: done next cycle, never busy.
        launch(0, 1'b1, 1, 1'b0);
        @(negedge clk);
        i_start = 1'b0;
        check("zero_done", int'(o_done), 1);
        bc = int'(o_busy);
        dc = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_busy) bc++;
            if (o_done) dc++;
        end
        check("zero_busy_never", bc, 0);
        check("zero_done_once", dc, 0);
        $display("zero: pos=%0d phase=%0d", o_pos, o_phase);

        // div = 0 behaves as div = 1.
        launch(1, 1'b1, 0, 1'b0);
        run_move(2000, bc, dc);
        check("div0_busy_cycles", bc, 8);
        check("div0_phase", int'(o_phase), 3);

        // Start pulsed mid-move is ignored.
        launch(2, 1'b1, 1, 1'b0);
        bc = 0;
        repeat (5) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_busy) bc++;
        end
        launch(1, 1'b0, 3, 1'b1);
        run_move(2000, bc2, dc);
        $display("ignore: busy=%0d pos=%0d phase=%0d", bc + bc2, o_pos, o_phase);
        check("ignore_busy_cycles", bc + bc2, 16);
        check("ignore_pos", int'(o_pos), 5);
        check("ignore_phase", int'(o_phase), 1);

        // Hold after a move from BC lands in CD with both coils at hold duty.
        launch(1, 1'b1, 1, 1'b1);
        run_move(2000, bc, dc);
        check("hold_a", int'(o_coil_a), 0);
        check("hold_b", int'(o_coil_b), 0);
        check("hold_c", int'(o_coil_c), 128);
        check("hold_d", int'(o_coil_d), 128);
        check("hold_busy", int'(o_busy), 0);

        // Start from HOLD is accepted (reverse, div 2).
        launch(1, 1'b0, 2, 1'b0);
        run_move(2000, bc, dc);
        $display("from_hold: busy=%0d pos=%0d phase=%0d", bc, o_pos, o_phase);
        check("fromhold_busy_cycles", bc, 16);
        check("fromhold_d_trail", q_d[0], 255);
        check("fromhold_c_lead", q_c[0], 7);
        check("fromhold_pos", int'(o_pos), 5);
        check("fromhold_phase", int'(o_phase), 1);

        // Reset in the middle of a move.
        launch(3, 1'b1, 1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_done", int'(o_done), 0);
        check("midrst_pos", int'(o_pos), 0);
        check("midrst_phase", int'(o_phase), 0);
        check("midrst_coils", coil_sum(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
